sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
- Per-sample controller for the audio path: ADC capture -> processor -> DAC.
- Generates the sample tick and launches one ADC conversion per tick.
- Hands the captured sample to the processor with a start/done handshake, then loads the result into the DAC interface.
- Detects sample-period overruns and handshake timeouts so a stalled processor or ADC cannot lock up the audio path.

Parameters:
DIVIDER, 4999, sample period in sysclk cycles minus 1 (4999 gives 10 kHz at 50 MHz)
TIMEOUT, 2000, maximum sysclk cycles spent waiting in ADC_WAIT or PROC_WAIT
DW, 10, sample data width

Ports:
sysclk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active-high
enable  input  1  sequencing enable; when low, ticks start no new frame
adc_start  output  1  one-cycle pulse to start an ADC conversion
adc_valid  input  1  ADC data valid pulse
adc_data  input  DW  ADC sample
proc_start  output  1  one-cycle pulse; proc_din is valid on this cycle
proc_din  output  DW  sample to processor
proc_done  input  1  processor result valid pulse
proc_dout  input  DW  processor result
dac_load  output  1  one-cycle pulse to start a DAC write
dac_data  output  DW  sample to DAC, held between loads
tick  output  1  one-cycle pulse per sample period
busy  output  1  high when state is not IDLE
overrun_cnt  output  8  count of ticks arriving while busy; saturates at 255
timeout_flag  output  1  sticky; set on any handshake timeout

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, period counter 0, timeout counter 0.
- Period counter:
  - Counts 0..DIVIDER and wraps to 0.
  - tick=1 on the cycle after the counter reaches DIVIDER, giving period DIVIDER+1 cycles.
  - Runs regardless of enable.
- States: IDLE, ADC_WAIT, PROC_WAIT, DAC_OUT.
- IDLE: on tick with enable=1, go to ADC_WAIT next cycle with adc_start=1 for that one cycle; clear the timeout counter.
- ADC_WAIT:
  - adc_valid is ignored on the adc_start cycle.
  - On adc_valid=1: proc_din<=adc_data, proc_start=1 next cycle, go to PROC_WAIT, clear the timeout counter.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: set timeout_flag, return to IDLE; dac_data is unchanged and no dac_load is issued.
- PROC_WAIT:
  - proc_done is ignored on the proc_start cycle.
  - On proc_done=1: dac_data<=proc_dout, dac_load=1 next cycle, go to DAC_OUT.
  - Timeout is handled exactly as in ADC_WAIT.
- DAC_OUT: lasts one cycle (the cycle dac_load=1), then IDLE.
- Nominal latency:
  - adc_start is 1 cycle after tick.
  - proc_start is 1 cycle after adc_valid.
  - dac_load is 1 cycle after proc_done.
- Overrun:
  - A tick while state!=IDLE increments overrun_cnt (saturating at 255) if enable=1.
  - The tick is dropped; the in-flight frame completes normally.
  - A tick arriving on the same cycle the state returns to IDLE counts as an overrun; the next frame starts on the following tick.
- enable low mid-frame: the current frame completes; no new frames start.
- adc_valid and proc_done pulses outside their wait states are ignored.
- timeout_flag and overrun_cnt clear only on rst.
- rst mid-frame: synchronous return to IDLE with all outputs 0 on the next edge; the period counter restarts at 0.

Test Plan:
- DIVIDER=19, enable=1, ADC returns valid 5 cycles after start with 0x155, processor returns done 3 cycles after start with 0x2AA -> tick every 20 cycles; adc_start 1 cycle after tick; proc_din=0x155 with proc_start; dac_data=0x2AA with dac_load; busy falls 1 cycle later.
- Processor done delayed to 30 cycles (DIVIDER=19, TIMEOUT=2000) -> one overrun per dropped tick, overrun_cnt=1 after the first frame; frame still completes with dac_load.
- ADC never asserts valid, TIMEOUT=8 -> timeout_flag=1 exactly 8 cycles after the adc_start cycle; no proc_start; dac_data holds its previous value; next tick starts a new frame.
- Stalled processor producing 300 overruns -> overrun_cnt saturates at 255.
- Assert rst during PROC_WAIT -> next cycle all outputs 0, state IDLE; a subsequent late proc_done is ignored; first tick comes DIVIDER+1 cycles after rst deasserts.
- enable=0 -> tick still pulses; no adc_start; overrun_cnt stays 0; spurious adc_valid/proc_done pulses cause no output change.

Source files
------------

// File: rtl/sample_sequencer.sv
// Per-sample sequencer for the audio path: sample tick -> ADC capture -> processor -> DAC load.
// Overruns (ticks while busy) are counted and stalled handshakes are abandoned after a timeout.
module sample_sequencer #(
  parameter int DIVIDER = 4999,
  parameter int TIMEOUT = 2000,
  parameter int DW      = 10
) (
  input  logic          i_sysclk,
  input  logic          i_rst,
  input  logic          i_enable,
  output logic          o_adc_start,
  input  logic          i_adc_valid,
  input  logic [DW-1:0] i_adc_data,
  output logic          o_proc_start,
  output logic [DW-1:0] o_proc_din,
  input  logic          i_proc_done,
  input  logic [DW-1:0] i_proc_dout,
  output logic          o_dac_load,
  output logic [DW-1:0] o_dac_data,
  output logic          o_tick,
  output logic          o_busy,
  output logic [7:0]    o_overrun_cnt,
  output logic          o_timeout_flag
);

  localparam int CW = $clog2(DIVIDER + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ADC_WAIT,
    PROC_WAIT,
    DAC_OUT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_period_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_tick;
  logic          r_adc_start;
  logic          r_proc_start;
  logic          r_dac_load;
  logic          r_busy;
  logic          r_timeout_flag;
  logic [DW-1:0] r_proc_din;
  logic [DW-1:0] r_dac_data;
  logic [7:0]    r_overrun_cnt;

  logic          w_period_wrap;
  logic          w_to_expired;
  logic          w_overrun;

  assign w_period_wrap = (r_period_cnt == CNT_LAST);
  assign w_to_expired  = (r_to_cnt == TO_LAST);
  assign w_overrun     = r_tick && i_enable && (r_state != IDLE);

  // Free-running period counter; tick is registered so it lands one cycle after the wrap value.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_period_cnt <= '0;
      r_tick       <= 1'b0;
    end else begin
      r_tick <= w_period_wrap;
      if (w_period_wrap) begin
        r_period_cnt <= '0;
      end else begin
        r_period_cnt <= r_period_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_to_cnt       <= '0;
      r_adc_start    <= 1'b0;
      r_proc_start   <= 1'b0;
      r_dac_load     <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_proc_din     <= '0;
      r_dac_data     <= '0;
      r_overrun_cnt  <= '0;
    end else begin
      r_adc_start  <= 1'b0;
      r_proc_start <= 1'b0;
      r_dac_load   <= 1'b0;

      if (w_overrun && (r_overrun_cnt != 8'hFF)) begin
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (r_tick && i_enable) begin
            r_state     <= ADC_WAIT;
            r_adc_start <= 1'b1;
            r_busy      <= 1'b1;
            r_to_cnt    <= '0;
          end
        end

        // The strobe cycle itself is excluded so a stale valid cannot complete the handshake.
        ADC_WAIT: begin
          if (i_adc_valid && !r_adc_start) begin
            r_proc_din   <= i_adc_data;
            r_proc_start <= 1'b1;
            r_state      <= PROC_WAIT;
            r_to_cnt     <= '0;
          end else if (w_to_expired) begin
            r_timeout_flag <= 1'b1;
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_to_cnt       <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end

        PROC_WAIT: begin
          if (i_proc_done && !r_proc_start) begin
            r_dac_data <= i_proc_dout;
            r_dac_load <= 1'b1;
            r_state    <= DAC_OUT;
            r_to_cnt   <= '0;
          end else if (w_to_expired) begin
            r_timeout_flag <= 1'b1;
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_to_cnt       <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end

        DAC_OUT: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tick         = r_tick;
  assign o_adc_start    = r_adc_start;
  assign o_proc_start   = r_proc_start;
  assign o_proc_din     = r_proc_din;
  assign o_dac_load     = r_dac_load;
  assign o_dac_data     = r_dac_data;
  assign o_busy         = r_busy;
  assign o_overrun_cnt  = r_overrun_cnt;
  assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: a behavioural ADC/processor responder pushes expected samples into
// queues that are popped when the sequencer hands them on; a second instance uses a short timeout.
module tb_sample_sequencer;

  localparam int DW  = 10;
  localparam int DIV = 19;
  localparam int K_TICK = 0, K_ADC = 1, K_PROC = 2, K_DAC = 3, K_TO_ADC = 4, K_TO_FLAG = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic adcValid = 1'b0;
  logic procDone = 1'b0;
  logic [DW-1:0] adcData = '0;
  logic [DW-1:0] procDout = '0;

  logic adcStart, procStart, dacLoad, tick, busy, timeoutFlag;
  logic [DW-1:0] procDin, dacData;
  logic [7:0] overrunCnt;

  logic toAdcStart, toProcStart, toDacLoad, toTick, toBusy, toTimeoutFlag;
  logic [DW-1:0] toProcDin, toDacData;
  logic [7:0] toOverrunCnt;

  int asserts = 0;
  int failures = 0;
  int cyc = 0;
  int nAdcStart = 0, nDacLoad = 0, nTick = 0, nToProcStart = 0;

  bit adcRespond = 1'b1;
  bit procRespond = 1'b1;
  int adcDelay = 5;
  int procDelay = 3;
  logic [DW-1:0] adcValue = 10'h155;
  logic [DW-1:0] procValue = 10'h2AA;
  logic [DW-1:0] expProcDin[$];
  logic [DW-1:0] expDac[$];

  sample_sequencer #(.DIVIDER(DIV), .TIMEOUT(2000), .DW(DW)) u_dut (
    .i_sysclk(clk), .i_rst(rst), .i_enable(enable),
    .o_adc_start(adcStart), .i_adc_valid(adcValid), .i_adc_data(adcData),
    .o_proc_start(procStart), .o_proc_din(procDin),
    .i_proc_done(procDone), .i_proc_dout(procDout),
    .o_dac_load(dacLoad), .o_dac_data(dacData), .o_tick(tick), .o_busy(busy),
    .o_overrun_cnt(overrunCnt), .o_timeout_flag(timeoutFlag)
  );

  sample_sequencer #(.DIVIDER(DIV), .TIMEOUT(8), .DW(DW)) u_dutTo (
    .i_sysclk(clk), .i_rst(rst), .i_enable(enable),
    .o_adc_start(toAdcStart), .i_adc_valid(adcValid), .i_adc_data(adcData),
    .o_proc_start(toProcStart), .o_proc_din(toProcDin),
    .i_proc_done(procDone), .i_proc_dout(procDout),
    .o_dac_load(toDacLoad), .o_dac_data(toDacData), .o_tick(toTick), .o_busy(toBusy),
    .o_overrun_cnt(toOverrunCnt), .o_timeout_flag(toTimeoutFlag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (adcStart === 1'b1) nAdcStart <= nAdcStart + 1;
    if (dacLoad === 1'b1) nDacLoad <= nDacLoad + 1;
    if (tick === 1'b1) nTick <= nTick + 1;
    if (toProcStart === 1'b1) nToProcStart <= nToProcStart + 1;
  end

  // ADC model: answers each conversion request adcDelay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (adcStart === 1'b1 && adcRespond) begin
        repeat (adcDelay) @(negedge clk);
        adcData = adcValue;
        adcValid = 1'b1;
        expProcDin.push_back(adcValue);
        @(negedge clk);
        adcValid = 1'b0;
      end
    end
  end

  // Processor model: answers each start procDelay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (procStart === 1'b1 && procRespond) begin
        repeat (procDelay) @(negedge clk);
        procDout = procValue;
        procDone = 1'b1;
        expDac.push_back(procValue);
        @(negedge clk);
        procDone = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit sigOf(input int kind);
    case (kind)
      K_TICK:    return tick === 1'b1;
      K_ADC:     return adcStart === 1'b1;
      K_PROC:    return procStart === 1'b1;
      K_DAC:     return dacLoad === 1'b1;
      K_TO_ADC:  return toAdcStart === 1'b1;
      K_TO_FLAG: return toTimeoutFlag === 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic waitFor(input int kind, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = sigOf(kind);
    end
  endtask

  // Long enough for any pending responder pulse to expire before queues are cleared.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    expProcDin.delete();
    expDac.delete();
    adcRespond = 1'b1;
    procRespond = 1'b1;
    enable = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int t0;
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if ({adcStart, procStart, dacLoad, tick, busy, timeoutFlag} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %b, required 000000", {adcStart, procStart, dacLoad, tick, busy, timeoutFlag});
    end
    asserts++;
    if ({procDin, dacData, overrunCnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: proc_din=%h dac_data=%h overrun=%0d, required all 0", procDin, dacData, overrunCnt);
    end
    rst = 1'b0;
    t0 = cyc;
    waitFor(K_TICK, 40, ok);
    asserts++;
    if (!ok || cyc - t0 != DIV + 1) begin
      failures++;
      $display("[TB] FAIL reset_first_tick: tick after %0d cycles (seen=%0b), required %0d", cyc - t0, ok, DIV + 1);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    int t0, tAdc, tProc, prevTick;
    logic [DW-1:0] exp;
    doReset();
    adcDelay = 5;
    procDelay = 3;
    prevTick = 0;
    for (int f = 0; f < 2; f++) begin
      adcValue = (f == 0) ? 10'h155 : 10'h0F0;
      procValue = (f == 0) ? 10'h2AA : 10'h30F;
      waitFor(K_TICK, 45, ok);
      t0 = cyc;
      if (f == 1) begin
        asserts++;
        if (!ok || t0 - prevTick != DIV + 1) begin
          failures++;
          $display("[TB] FAIL nominal_tick_period: period %0d (seen=%0b), required %0d", t0 - prevTick, ok, DIV + 1);
        end
      end
      prevTick = t0;
      waitFor(K_ADC, 3, ok);
      asserts++;
      if (!ok || cyc - t0 != 1) begin
        failures++;
        $display("[TB] FAIL nominal_adc_start_latency: %0d (seen=%0b), required 1", cyc - t0, ok);
      end
      tAdc = cyc;
      waitFor(K_PROC, 20, ok);
      asserts++;
      if (!ok || cyc - tAdc != adcDelay + 1) begin
        failures++;
        $display("[TB] FAIL nominal_proc_start_latency: %0d (seen=%0b), required %0d", cyc - tAdc, ok, adcDelay + 1);
      end
      if (expProcDin.size() > 0) exp = expProcDin.pop_front(); else exp = 'x;
      asserts++;
      if (procDin !== exp) begin
        failures++;
        $display("[TB] FAIL nominal_proc_din: got %h, required %h", procDin, exp);
      end
      tProc = cyc;
      waitFor(K_DAC, 20, ok);
      asserts++;
      if (!ok || cyc - tProc != procDelay + 1) begin
        failures++;
        $display("[TB] FAIL nominal_dac_load_latency: %0d (seen=%0b), required %0d", cyc - tProc, ok, procDelay + 1);
      end
      if (expDac.size() > 0) exp = expDac.pop_front(); else exp = 'x;
      asserts++;
      if (dacData !== exp || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL nominal_dac_data: got %h busy=%b, required %h busy=1", dacData, busy, exp);
      end
      @(negedge clk);
      asserts++;
      if (busy !== 1'b0 || dacLoad !== 1'b0) begin
        failures++;
        $display("[TB] FAIL nominal_busy_fall: busy=%b dac_load=%b, required 0 0", busy, dacLoad);
      end
    end
    asserts++;
    if (toDacData !== 10'h30F) begin
      failures++;
      $display("[TB] FAIL nominal_short_timeout_instance: dac_data %h, required 30f", toDacData);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int t0;
    logic [DW-1:0] exp;
    doReset();
    adcDelay = 5;
    procDelay = 30;
    adcValue = 10'h0AB;
    procValue = 10'h3C4;
    waitFor(K_TICK, 45, ok);
    t0 = cyc;
    for (int f = 0; f < 2; f++) begin
      waitFor(K_DAC, 60, ok);
      asserts++;
      if (!ok || cyc - t0 != 38 + 40 * f) begin
        failures++;
        $display("[TB] FAIL overrun_dac_load_time: %0d (seen=%0b), required %0d", cyc - t0, ok, 38 + 40 * f);
      end
      if (expDac.size() > 0) exp = expDac.pop_front(); else exp = 'x;
      asserts++;
      if (dacData !== exp || overrunCnt !== 8'(f + 1)) begin
        failures++;
        $display("[TB] FAIL overrun_count: dac_data=%h overrun=%0d, required %h %0d", dacData, overrunCnt, exp, f + 1);
      end
      if (f == 0) begin
        waitFor(K_ADC, 5, ok);
        asserts++;
        if (!ok || cyc - t0 != 41) begin
          failures++;
          $display("[TB] FAIL overrun_next_frame: adc_start at %0d (seen=%0b), required 41", cyc - t0, ok);
        end
      end
    end
  endtask

  task automatic test_overrun_boundary();
    bit ok;
    int t0;
    doReset();
    adcDelay = 5;
    procDelay = 12;
    waitFor(K_TICK, 45, ok);
    t0 = cyc;
    waitFor(K_DAC, 30, ok);
    asserts++;
    if (!ok || cyc - t0 != DIV + 1 || tick !== 1'b1) begin
      failures++;
      $display("[TB] FAIL boundary_tick_on_dac_out: dac_load at %0d tick=%b (seen=%0b), required %0d tick=1", cyc - t0, tick, ok, DIV + 1);
    end
    @(negedge clk);
    asserts++;
    if (overrunCnt !== 8'd1 || adcStart !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boundary_overrun_counted: overrun=%0d adc_start=%b busy=%b, required 1 0 0", overrunCnt, adcStart, busy);
    end
    waitFor(K_ADC, 30, ok);
    asserts++;
    if (!ok || cyc - t0 != 2 * (DIV + 1) + 1) begin
      failures++;
      $display("[TB] FAIL boundary_next_frame: adc_start at %0d (seen=%0b), required %0d", cyc - t0, ok, 2 * (DIV + 1) + 1);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int a, n;
    doReset();
    adcDelay = 5;
    procDelay = 3;
    adcValue = 10'h0C3;
    procValue = 10'h1C3;
    waitFor(K_DAC, 45, ok);
    asserts++;
    if (!ok || toDacData !== 10'h1C3) begin
      failures++;
      $display("[TB] FAIL timeout_prior_frame: dac_data %h (seen=%0b), required 1c3", toDacData, ok);
    end
    adcRespond = 1'b0;
    waitFor(K_TO_ADC, 30, ok);
    a = cyc;
    n = nToProcStart;
    waitFor(K_TO_FLAG, 20, ok);
    asserts++;
    if (!ok || cyc - a != 8) begin
      failures++;
      $display("[TB] FAIL timeout_flag_time: flag %0d cycles after adc_start (seen=%0b), required 8", cyc - a, ok);
    end
    asserts++;
    if (toBusy !== 1'b0 || toDacData !== 10'h1C3 || timeoutFlag !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_state: busy=%b dac_data=%h long_timeout_flag=%b, required 0 1c3 0", toBusy, toDacData, timeoutFlag);
    end
    waitFor(K_TO_ADC, 30, ok);
    asserts++;
    if (!ok || cyc - a != DIV + 1 || nToProcStart != n) begin
      failures++;
      $display("[TB] FAIL timeout_restart: next adc_start at %0d proc_starts=%0d (seen=%0b), required %0d 0", cyc - a, nToProcStart - n, ok, DIV + 1);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int tRel, nd;
    doReset();
    adcDelay = 5;
    procDelay = 20;
    adcValue = 10'h2D2;
    procValue = 10'h11E;
    waitFor(K_TICK, 45, ok);
    waitFor(K_PROC, 30, ok);
    asserts++;
    if (!ok || procDin !== 10'h2D2) begin
      failures++;
      $display("[TB] FAIL rstmid_proc_start: proc_din %h (seen=%0b), required 2d2", procDin, ok);
    end
    repeat (5) @(negedge clk);
    nd = nDacLoad;
    rst = 1'b1;
    @(negedge clk);
    asserts++;
    if ({adcStart, procStart, dacLoad, tick, busy, timeoutFlag, procDin, dacData, overrunCnt} !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs: busy=%b proc_din=%h dac_data=%h overrun=%0d, required all 0", busy, procDin, dacData, overrunCnt);
    end
    rst = 1'b0;
    tRel = cyc;
    waitFor(K_TICK, 40, ok);
    asserts++;
    if (!ok || cyc - tRel != DIV + 1) begin
      failures++;
      $display("[TB] FAIL rstmid_first_tick: %0d (seen=%0b), required %0d", cyc - tRel, ok, DIV + 1);
    end
    asserts++;
    if (nDacLoad != nd || dacData !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_late_done_ignored: dac_loads=%0d dac_data=%h, required 0 000", nDacLoad - nd, dacData);
    end
  endtask

  task automatic test_enable();
    bit ok;
    int t0, na, nt;
    logic [DW-1:0] exp;
    doReset();
    adcDelay = 5;
    procDelay = 20;
    adcValue = 10'h077;
    procValue = 10'h388;
    waitFor(K_TICK, 45, ok);
    t0 = cyc;
    waitFor(K_ADC, 3, ok);
    enable = 1'b0;
    waitFor(K_DAC, 40, ok);
    if (expDac.size() > 0) exp = expDac.pop_front(); else exp = 'x;
    asserts++;
    if (!ok || cyc - t0 != 28 || dacData !== exp) begin
      failures++;
      $display("[TB] FAIL enable_low_frame_completes: dac_load at %0d data %h (seen=%0b), required 28 %h", cyc - t0, dacData, ok, exp);
    end
    na = nAdcStart;
    nt = nTick;
    @(negedge clk);
    adcData = 10'h3FF;
    adcValid = 1'b1;
    procDout = 10'h3FF;
    procDone = 1'b1;
    @(negedge clk);
    adcValid = 1'b0;
    procDone = 1'b0;
    repeat (40) @(negedge clk);
    asserts++;
    if (nAdcStart != na || nTick - nt != 2) begin
      failures++;
      $display("[TB] FAIL enable_low_ticks: adc_starts=%0d ticks=%0d, required 0 2", nAdcStart - na, nTick - nt);
    end
    asserts++;
    if (overrunCnt !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL enable_low_overrun: overrun=%0d busy=%b, required 0 0", overrunCnt, busy);
    end
    asserts++;
    if (procDin !== 10'h077 || dacData !== 10'h388) begin
      failures++;
      $display("[TB] FAIL enable_low_spurious_ignored: proc_din=%h dac_data=%h, required 077 388", procDin, dacData);
    end
  endtask

  // Each stalled frame drops 100 ticks before the 2000-cycle timeout, so three stalls exceed 255.
  task automatic test_saturation();
    bit ok;
    int t0, e;
    doReset();
    adcDelay = 5;
    procRespond = 1'b0;
    waitFor(K_TICK, 45, ok);
    t0 = cyc;
    for (int s = 1; s <= 3; s++) begin
      repeat (t0 + 2020 * (s - 1) + 2010 - cyc) @(negedge clk);
      e = 100 * s;
      if (e > 255) e = 255;
      asserts++;
      if (overrunCnt !== 8'(e) || timeoutFlag !== 1'b1) begin
        failures++;
        $display("[TB] FAIL saturation_stall%0d: overrun=%0d flag=%b, required %0d 1", s, overrunCnt, timeoutFlag, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_overrun_boundary();
    test_timeout();
    test_reset_midframe();
    test_enable();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
